// File: rtl/step_gen_pkg.sv
// Shared types and helpers for the step/direction pulse generator.
// Period arithmetic is done on 32-bit values and narrowed by the caller.
package step_gen_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        HIGH,
        LOW,
        FINISH
    } state_t;

    localparam int unsigned MIN_PERIOD = 2;

    function automatic logic [31:0] eff_period(input logic [31:0] period);
        return (period < MIN_PERIOD) ? MIN_PERIOD : period;
    endfunction

    function automatic logic [31:0] high_len(input logic [31:0] period);
        return period >> 1;
    endfunction

endpackage

// File: rtl/step_timer.sv
// Loadable down-counter; expire is high while the count sits at zero.
// Loading N-1 makes expire rise in the Nth cycle after the load edge.
module step_timer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expire
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire = (cnt_q == '0);

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator for one axis: command intake, DIR setup,
// step high/low phasing, abort handling and the signed position counter.
module step_pulse_gen
    import step_gen_pkg::*;
#(
    parameter int CNT_W     = 32,
    parameter int PERIOD_W  = 16,
    parameter int DIR_SETUP = 4
) (
    input  logic                ACLK,
    input  logic                ARESET,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [CNT_W-1:0]    cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    input  logic                pos_load,
    input  logic [CNT_W-1:0]    pos_value,
    output logic                step,
    output logic                dir,
    output logic                busy,
    output logic                done,
    output logic [CNT_W-1:0]    position,
    output state_t              dbg_state
);

    localparam logic [PERIOD_W-1:0] SETUP_LOAD = PERIOD_W'(DIR_SETUP - 1);

    // Handshake: a command transfers on any edge where cmd_valid and
    // cmd_ready are both high; cmd_ready depends on state only.

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [CNT_W-1:0]    remaining_q, remaining_d;
    logic [CNT_W-1:0]    position_q, position_d;
    logic                dir_q, dir_d;
    logic                step_q, step_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic                tmr_load;
    logic [PERIOD_W-1:0] tmr_val;
    logic                tmr_expire;
    logic                enter_high;
    logic [CNT_W-1:0]    steps_abs;
    logic [PERIOD_W-1:0] hi_len;
    logic [PERIOD_W-1:0] lo_len;

    step_timer #(.W(PERIOD_W)) u_timer (
        .clk      (ACLK),
        .rst      (ARESET),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expire   (tmr_expire)
    );

    // Most negative delta maps to 2^(CNT_W-1), which fits as unsigned.
    assign steps_abs = cmd_steps[CNT_W-1] ? (CNT_W'(0) - cmd_steps) : cmd_steps;
    assign hi_len    = PERIOD_W'(high_len(32'(period_q)));
    assign lo_len    = period_q - hi_len;

    always_comb begin
        state_d     = state_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        position_d  = position_q;
        dir_d       = dir_q;
        step_d      = step_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        tmr_load    = 1'b0;
        tmr_val     = '0;
        enter_high  = 1'b0;

        case (state_q)
            IDLE: begin
                if (pos_load) begin
                    position_d = pos_value;
                end
                if (cmd_valid) begin
                    remaining_d = steps_abs;
                    period_d    = PERIOD_W'(eff_period(32'(cmd_period)));
                    if (cmd_steps == '0) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                    end else begin
                        dir_d    = ~cmd_steps[CNT_W-1];
                        busy_d   = 1'b1;
                        state_d  = SETUP;
                        tmr_load = 1'b1;
                        tmr_val  = SETUP_LOAD;
                    end
                end
            end
            SETUP: begin
                if (tmr_expire) begin
                    enter_high = 1'b1;
                end
            end
            HIGH: begin
                if (tmr_expire) begin
                    state_d  = LOW;
                    step_d   = 1'b0;
                    tmr_load = 1'b1;
                    tmr_val  = lo_len - PERIOD_W'(1);
                end
            end
            LOW: begin
                if (tmr_expire) begin
                    if (remaining_q != '0) begin
                        enter_high = 1'b1;
                    end else begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (enter_high) begin
            state_d     = HIGH;
            step_d      = 1'b1;
            position_d  = dir_q ? (position_q + CNT_W'(1)) : (position_q - CNT_W'(1));
            remaining_d = remaining_q - CNT_W'(1);
            tmr_load    = 1'b1;
            tmr_val     = hi_len - PERIOD_W'(1);
        end

        // Abort beats any timer expiry in the same cycle, so no new edge is counted.
        if (abort && (state_q inside {SETUP, HIGH, LOW})) begin
            state_d     = FINISH;
            step_d      = 1'b0;
            remaining_d = '0;
            position_d  = position_q;
            done_d      = 1'b1;
            busy_d      = 1'b0;
            tmr_load    = 1'b0;
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q     <= IDLE;
            period_q    <= PERIOD_W'(MIN_PERIOD);
            remaining_q <= '0;
            position_q  <= '0;
            dir_q       <= 1'b1;
            step_q      <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            position_q  <= position_d;
            dir_q       <= dir_d;
            step_q      <= step_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign step      = step_q;
    assign dir       = dir_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign position  = position_q;
    assign dbg_state = state_q;

endmodule
